// File: rtl/add_serial_nbits.sv
// Bit-serial adder: a_i + b_i + cin_i, one bit per clock, LSB first, via one full-adder slice.
// Optional macro SERIAL_ADD_OVF_EN adds the ovf_o signed-overflow output.
module add_serial_nbits #(
    parameter int unsigned width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [width-1:0] s_o,
    output logic             cout_o
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int unsigned CNT_W = $clog2(width);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(width - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [width-1:0] a_sh;
    logic [width-1:0] b_sh;
    logic [width-1:0] res_sh;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             sum_bit;
    logic             carry_nxt;
`ifdef SERIAL_ADD_OVF_EN
    logic             carry_msb_in;
`endif

    always_comb begin
        sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            s_o    <= '0;
            cout_o <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            carry_msb_in <= 1'b0;
            ovf_o        <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        a_sh   <= a_i;
                        b_sh   <= b_i;
                        carry  <= cin_i;
                        cnt    <= '0;
                        state  <= S_RUN;
                        busy_o <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Sum bits enter at the MSB so after width shifts bit 0 sits at the LSB.
                    res_sh <= {sum_bit, res_sh[width-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= carry_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= S_DONE;
`ifdef SERIAL_ADD_OVF_EN
                        carry_msb_in <= carry;
`endif
                    end
                end
                S_DONE: begin
                    s_o    <= res_sh;
                    cout_o <= carry;
                    done_o <= 1'b1;
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_o  <= carry_msb_in ^ carry;
`endif
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_serial_nbits.sv
// Directed self-checking bench for add_serial_nbits (width=8); covers ovf_o when SERIAL_ADD_OVF_EN is defined.
module tb_add_serial_nbits;

    localparam int unsigned W = 8;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         cin_i = 1'b0;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] s_o;
    logic         cout_o;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf_o;
`endif

    int tests = 0;
    int fails = 0;

    add_serial_nbits #(.width(W)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cin_i   (cin_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .s_o     (s_o),
        .cout_o  (cout_o)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf_o   (ovf_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Starts one operation at a negedge, scrambles the inputs afterwards, and checks
    // latency, busy length, single done pulse and result.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] exp_s, input logic exp_c);
        int cyc;
        int busy_cnt;
        @(negedge clk_i);
        start_i = 1'b1; a_i = a; b_i = b; cin_i = cin;
        @(negedge clk_i);
        start_i = 1'b0; a_i = ~a; b_i = b ^ 8'h5A; cin_i = ~cin;
        cyc = 0;
        busy_cnt = 0;
        while (!done_o && cyc < 30) begin
            if (busy_o) busy_cnt++;
            @(negedge clk_i);
            cyc++;
        end
        tests++;
        if (cyc !== 9) begin
            fails++;
            $display("FAIL %s latency: got %0d cycles, expected 9", name, cyc);
        end
        tests++;
        if (busy_cnt !== 9) begin
            fails++;
            $display("FAIL %s busy_len: got %0d, expected 9", name, busy_cnt);
        end
        tests++;
        if (s_o !== exp_s) begin
            fails++;
            $display("FAIL %s s_o: got %h, expected %h", name, s_o, exp_s);
        end
        tests++;
        if (cout_o !== exp_c) begin
            fails++;
            $display("FAIL %s cout_o: got %b, expected %b", name, cout_o, exp_c);
        end
        @(negedge clk_i);
        tests++;
        if (done_o !== 1'b0) begin
            fails++;
            $display("FAIL %s done_width: done_o still %b, expected 0", name, done_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        tests++;
        if ({busy_o, done_o, s_o, cout_o} !== '0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b s=%h cout=%b, expected all 0", busy_o, done_o, s_o, cout_o);
        end
`ifdef SERIAL_ADD_OVF_EN
        tests++;
        if (ovf_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_ovf: got %b, expected 0", ovf_o);
        end
`endif
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_basic();
        run_op("basic_3c_05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
    endtask

    task automatic test_wrap();
        run_op("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("wrap_ff_00_cin", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run_op("mixed_a5_5a_cin", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    endtask

    task automatic test_start_while_busy();
        int cyc;
        int pulses;
        @(negedge clk_i);
        start_i = 1'b1; a_i = 8'h10; b_i = 8'h20; cin_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        start_i = 1'b1; a_i = 8'hAA; b_i = 8'h55; cin_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cyc = 0;
        pulses = 0;
        while (cyc < 25) begin
            if (done_o) begin
                pulses++;
                tests++;
                if (s_o !== 8'h30 || cout_o !== 1'b0) begin
                    fails++;
                    $display("FAIL busy_ignore result: s=%h cout=%b, expected 30/0", s_o, cout_o);
                end
            end
            @(negedge clk_i);
            cyc++;
        end
        tests++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL busy_ignore pulses: got %0d, expected 1", pulses);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        @(negedge clk_i);
        start_i = 1'b1; a_i = 8'h7F; b_i = 8'h01; cin_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tests++;
        if (busy_o !== 1'b0 || s_o !== 8'h00 || cout_o !== 1'b0) begin
            fails++;
            $display("FAIL abort_state: busy=%b s=%h cout=%b, expected 0/00/0", busy_o, s_o, cout_o);
        end
        pulses = 0;
        repeat (15) begin
            @(negedge clk_i);
            if (done_o) pulses++;
        end
        tests++;
        if (pulses !== 0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_done: pulses=%0d busy=%b, expected 0/0", pulses, busy_o);
        end
        run_op("after_abort_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk_i);
        start_i = 1'b1; a_i = 8'h01; b_i = 8'h01; cin_i = 1'b0;
        cyc = 0;
        while (!done_o && cyc < 30) begin
            @(negedge clk_i);
            cyc++;
        end
        tests++;
        if (!done_o) begin
            fails++;
            $display("FAIL b2b first_done: no done_o within %0d cycles", cyc);
        end
        for (int p = 0; p < 3; p++) begin
            tests++;
            if (s_o !== 8'h02) begin
                fails++;
                $display("FAIL b2b result%0d: s=%h, expected 02", p, s_o);
            end
            cyc = 0;
            @(negedge clk_i);
            cyc++;
            while (!done_o && cyc < 30) begin
                @(negedge clk_i);
                cyc++;
            end
            tests++;
            if (cyc !== 10) begin
                fails++;
                $display("FAIL b2b period%0d: got %0d cycles, expected 10", p, cyc);
            end
        end
        start_i = 1'b0;
        cyc = 0;
        while (busy_o && cyc < 30) begin
            @(negedge clk_i);
            cyc++;
        end
        repeat (2) @(negedge clk_i);
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] va [3] = '{8'h7F, 8'h80, 8'hFF};
        logic [W-1:0] vb [3] = '{8'h01, 8'h80, 8'h01};
        logic [W-1:0] es [3] = '{8'h80, 8'h00, 8'h00};
        logic         ec [3] = '{1'b0, 1'b1, 1'b1};
        logic         eo [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_op("ovf_case", va[i], vb[i], 1'b0, es[i], ec[i]);
            tests++;
            if (ovf_o !== eo[i]) begin
                fails++;
                $display("FAIL ovf%0d: got %b, expected %b", i, ovf_o, eo[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_start_while_busy();
        test_reset_abort();
        test_back_to_back();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/add_serial_nbits.md
Name: add_serial_nbits

Overview:
Multi-cycle bit-serial adder for the calculator datapath; it computes a_i + b_i + cin_i one bit per clock, LSB first, through a single full-adder slice and a carry flop.
- Complements the combinational ripple subtractor: the same operand width and carry semantics, but in the opposite arithmetic direction (sum rather than difference), traded for area.
- Sits between the operand registers and the result register; it is started by the calculator control FSM with a start/done handshake.

Parameters:
width, 8, operand and result width in bits (must be >= 2)

Ports:
clk_i  input  1  system clock; all state updates on rising edge
rst_ni  input  1  synchronous active-low reset
start_i  input  1  request an addition; sampled only in IDLE
a_i  input  width  operand A, captured on the accepted start edge
b_i  input  width  operand B, captured on the accepted start edge
cin_i  input  1  carry-in, captured on the accepted start edge
busy_o  output  1  high while an addition is in progress
done_o  output  1  single-cycle pulse when the result is valid
s_o  output  width  sum a+b+cin mod 2^width, held until the next completion
cout_o  output  1  carry out of bit width-1, held with s_o

Behaviour:
- Reset (rst_ni low at a rising edge): state=IDLE; busy_o=0, done_o=0, s_o=0, cout_o=0; internal shift registers, bit counter and carry flop cleared. Reset overrides every other input, including mid-operation: the operation aborts and no done_o is produced.
- FSM states:
  - IDLE: start_i=1 at an edge → latch a_i, b_i into shift registers, carry flop <= cin_i, counter <= 0, go to RUN.
  - RUN: each edge computes a full-adder on the LSBs of A, B and the carry flop. The sum bit shifts into the MSB of the result shift register (LSB-first fill), A and B shift right, carry flop <= carry out, counter++. On the edge where counter == width-1 → go to DONE.
  - DONE: s_o <= result register, cout_o <= final carry, done_o=1 for exactly this one cycle, then unconditionally return to IDLE.
- busy_o = 1 in RUN and DONE, 0 in IDLE (registered from state).
- Latency: start accepted at edge k; bits are processed on edges k+1..k+width; done_o and the new s_o/cout_o are visible after edge k+width+1. Total width+1 cycles from acceptance to done_o.
- start_i while busy_o=1: ignored; operands and cin_i not re-sampled, no queuing.
- start_i held high continuously: a new operation is accepted in the first IDLE cycle after DONE. Back-to-back throughput is one result per width+2 cycles.
- Operand changes on a_i/b_i/cin_i after acceptance have no effect on the result in flight.
- s_o/cout_o change only on the DONE transition. Between operations they hold the last result, or 0 after reset.
- Wrap-around: sum is modulo 2^width; cout_o=1 exactly when a+b+cin >= 2^width.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined: adds output ovf_o (1 bit), the two's-complement signed overflow of the addition, computed as carry into bit width-1 XOR carry out of bit width-1. It is updated with s_o on the DONE edge, held otherwise, and reset to 0.
- Not defined: no ovf_o port, and no extra flop for the bit-(width-1) carry-in.

Test Plan:
1. width=8, reset then start with a=0x3C, b=0x05, cin=0 → done_o pulses once 9 cycles after acceptance; s_o=0x41, cout_o=0, busy_o high for exactly 9 cycles.
2. a=0xFF, b=0x01, cin=0 → s_o=0x00, cout_o=1. Then a=0xFF, b=0x00, cin=1 → s_o=0x00, cout_o=1. Then a=0x00, b=0x00, cin=0 → s_o=0x00, cout_o=0.
3. Start a=0x10, b=0x20; pulse start_i with a=0xAA, b=0x55 mid-RUN → the second request is ignored; s_o=0x30, cout_o=0, a single done_o pulse.
4. Start a=0x7F, b=0x01; drive rst_ni low for one cycle at bit 4 → busy_o=0, s_o=0 and no done_o after release. A fresh start with a=0x12, b=0x34 → s_o=0x46.
5. start_i held high with a=0x01, b=0x01 → done_o pulses every 10 cycles, s_o=0x02 each time, no missed or merged pulses.
6. With SERIAL_ADD_OVF_EN defined: a=0x7F, b=0x01 → s_o=0x80, cout_o=0, ovf_o=1. a=0x80, b=0x80 → s_o=0x00, cout_o=1, ovf_o=1. a=0xFF, b=0x01 → ovf_o=0.
